s100_slave_port: RTL and testbench

S-100 (IEEE-696) bus responder for the T35 SBC family: the target-side counterpart of the SBC's bus-master front end. It samples the master-driven address, status and control strobes, decodes an I/O port window and an optional memory window, and converts each hit into a single-cycle register read/write on a local back-end interface. It inserts wait states on RDY until the back end acknowledges, and drives read data onto the bus data-in lines with an output-enable.

---
 rtl/s100_slave_pkg.sv | 13 +
 rtl/s100_sync.sv | 28 ++
 rtl/s100_slave_port.sv | 220 ++++++++++++++++++++++
 tb/tb_s100_slave_port.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/s100_slave_pkg.sv
// Shared types and constants for the S-100 bus slave port.
package s100_slave_pkg;

  typedef enum logic [3:0] {
    IDLE, LATCH, REQ_RD, WAIT_RD, DRIVE, WAIT_WR, REQ_WR, WAIT_ACK_WR, DONE
  } state_t;

  typedef enum logic [1:0] {IO_RD, IO_WR, MEM_RD, MEM_WR} cyc_t;

  localparam int         SYNC_DEPTH    = 2;
  localparam logic [7:0] TIMEOUT_RDATA = 8'hFF;

endpackage

// File: rtl/s100_sync.sv
// Multi-flop synchronizer for a bundle of asynchronous bus inputs.
// Each bit resets to its own idle level so no false edge appears after reset.
module s100_sync
  import s100_slave_pkg::*;
#(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_reg [SYNC_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_DEPTH; i++) stage_reg[i] <= RST_VAL;
    end else begin
      stage_reg[0] <= d;
      for (int i = 1; i < SYNC_DEPTH; i++) stage_reg[i] <= stage_reg[i-1];
    end
  end

  assign q = stage_reg[SYNC_DEPTH-1];

endmodule

// File: rtl/s100_slave_port.sv
// S-100 bus slave: turns decoded I/O (and optionally memory) cycles into back-end register requests.
// Define S100_SLAVE_MEM_EN to enable the memory-window decode and reg_is_mem.
module s100_slave_port
  import s100_slave_pkg::*;
#(
  parameter logic [7:0]  IO_BASE     = 8'hA0,
  parameter logic [7:0]  IO_MASK     = 8'hF0,
  parameter logic [19:0] MEM_BASE    = 20'hE0000,
  parameter logic [19:0] MEM_MASK    = 20'hF0000,
  parameter int          TIMEOUT_CYC = 255
) (
  input  logic        clockIn,
  input  logic        s100_n_RESET,
  input  logic [19:0] bus_adr,
  input  logic [7:0]  bus_din,
  input  logic        bus_sINP,
  input  logic        bus_sOUT,
  input  logic        bus_sMEMR,
  input  logic        bus_sMWRT,
  input  logic        bus_pSYNC,
  input  logic        bus_n_pSTVAL,
  input  logic        bus_pDBIN,
  input  logic        bus_n_pWR,
  output logic [7:0]  bus_dout,
  output logic        bus_dout_oe,
  output logic        bus_rdy,
  output logic [19:0] reg_addr,
  output logic        reg_rd,
  output logic        reg_wr,
  output logic [7:0]  reg_wdata,
  input  logic [7:0]  reg_rdata,
  input  logic        reg_ack,
  output logic        reg_is_mem,
  output logic        timeout_err
);

  localparam int              SYNC_W      = 36;
  localparam logic [SYNC_W-1:0] SYNC_RST  = 36'h5;  // n_pSTVAL and n_pWR idle high
  localparam logic [7:0]      TIMEOUT_LIM = 8'(TIMEOUT_CYC);

  logic [SYNC_W-1:0] sync_q;
  logic [19:0] s_adr;
  logic [7:0]  s_din;
  logic s_sinp, s_sout, s_smemr, s_smwrt, s_psync, s_n_pstval, s_pdbin, s_n_pwr;

  s100_sync #(.WIDTH(SYNC_W), .RST_VAL(SYNC_RST)) u_sync (
    .clk   (clockIn),
    .rst_n (s100_n_RESET),
    .d     ({bus_adr, bus_din, bus_sINP, bus_sOUT, bus_sMEMR, bus_sMWRT,
             bus_pSYNC, bus_n_pSTVAL, bus_pDBIN, bus_n_pWR}),
    .q     (sync_q)
  );

  assign {s_adr, s_din, s_sinp, s_sout, s_smemr, s_smwrt,
          s_psync, s_n_pstval, s_pdbin, s_n_pwr} = sync_q;

  state_t      state_reg, state_next;
  logic [3:0]  stat_reg, stat_next;  // {sINP, sOUT, sMEMR, sMWRT}
  logic [19:0] addr_reg, addr_next;
  logic [7:0]  wdata_reg, wdata_next, dout_reg, dout_next, cnt_reg, cnt_next;
  logic oe_reg, oe_next, rdy_reg, rdy_next, rd_reg, rd_next, wr_reg, wr_next;
  logic is_mem_reg, is_mem_next, err_reg, err_next;
  logic stval_prev_reg, pdbin_prev_reg, n_pwr_prev_reg;
  logic stval_fall, pdbin_fall, n_pwr_rise, expired;
  logic io_hit, mem_hit, hit;
  cyc_t cyc_type;

  assign stval_fall = stval_prev_reg & ~s_n_pstval;
  assign pdbin_fall = pdbin_prev_reg & ~s_pdbin;
  assign n_pwr_rise = ~n_pwr_prev_reg & s_n_pwr;
  assign expired    = (cnt_reg == TIMEOUT_LIM);

  assign io_hit = (stat_reg[3] | stat_reg[2]) &&
                  ((addr_reg[7:0] & IO_MASK) == (IO_BASE & IO_MASK));
`ifdef S100_SLAVE_MEM_EN
  assign mem_hit = (stat_reg[1] | stat_reg[0]) &&
                   ((addr_reg & MEM_MASK) == (MEM_BASE & MEM_MASK));
`else
  logic unused_mem;
  assign mem_hit    = 1'b0;
  assign unused_mem = ^{MEM_BASE, MEM_MASK};
`endif
  assign hit = io_hit | mem_hit;

  always_comb begin
    if (mem_hit) cyc_type = stat_reg[1] ? MEM_RD : MEM_WR;
    else         cyc_type = stat_reg[3] ? IO_RD : IO_WR;
  end

  always_comb begin
    state_next  = state_reg;
    stat_next   = stat_reg;
    addr_next   = addr_reg;
    wdata_next  = wdata_reg;
    dout_next   = dout_reg;
    oe_next     = oe_reg;
    rdy_next    = rdy_reg;
    is_mem_next = is_mem_reg;
    err_next    = err_reg;
    rd_next     = 1'b0;
    wr_next     = 1'b0;
    cnt_next    = '0;
    case (state_reg)
      IDLE: if (s_psync && stval_fall) begin
        state_next = LATCH;
        addr_next  = s_adr;
        stat_next  = {s_sinp, s_sout, s_smemr, s_smwrt};
      end
      LATCH: begin
        if (!hit) begin
          state_next = DONE;
        end else begin
          rdy_next    = 1'b0;
          is_mem_next = mem_hit;
          if (cyc_type == IO_RD || cyc_type == MEM_RD) begin
            state_next = REQ_RD;
            rd_next    = 1'b1;
          end else begin
            state_next = WAIT_WR;
          end
        end
      end
      REQ_RD: state_next = WAIT_RD;
      WAIT_RD: begin
        // Master abort beats a late ack; an ack beats the timeout.
        if (pdbin_fall) begin
          state_next = DONE;
          rdy_next   = 1'b1;
          oe_next    = 1'b0;
        end else if (reg_ack) begin
          state_next = DRIVE;
          dout_next  = reg_rdata;
          rdy_next   = 1'b1;
        end else if (expired) begin
          state_next = DRIVE;
          dout_next  = TIMEOUT_RDATA;
          rdy_next   = 1'b1;
          err_next   = 1'b1;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      DRIVE: begin
        if (s_psync || !s_pdbin) begin
          oe_next    = 1'b0;
          state_next = DONE;
        end else begin
          oe_next = 1'b1;
        end
      end
      WAIT_WR: if (!s_n_pwr) begin
        wdata_next = s_din;
        wr_next    = 1'b1;
        state_next = REQ_WR;
      end
      REQ_WR: state_next = WAIT_ACK_WR;
      WAIT_ACK_WR: begin
        if (n_pwr_rise || reg_ack) begin
          state_next = DONE;
          rdy_next   = 1'b1;
        end else if (expired) begin
          state_next = DONE;
          rdy_next   = 1'b1;
          err_next   = 1'b1;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      DONE: if (!s_psync && s_n_pstval && !s_pdbin && s_n_pwr) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clockIn or negedge s100_n_RESET) begin
    if (!s100_n_RESET) begin
      state_reg      <= IDLE;
      stat_reg       <= '0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      dout_reg       <= '0;
      cnt_reg        <= '0;
      oe_reg         <= 1'b0;
      rdy_reg        <= 1'b1;
      rd_reg         <= 1'b0;
      wr_reg         <= 1'b0;
      is_mem_reg     <= 1'b0;
      err_reg        <= 1'b0;
      stval_prev_reg <= 1'b1;
      pdbin_prev_reg <= 1'b0;
      n_pwr_prev_reg <= 1'b1;
    end else begin
      state_reg      <= state_next;
      stat_reg       <= stat_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      dout_reg       <= dout_next;
      cnt_reg        <= cnt_next;
      oe_reg         <= oe_next;
      rdy_reg        <= rdy_next;
      rd_reg         <= rd_next;
      wr_reg         <= wr_next;
      is_mem_reg     <= is_mem_next;
      err_reg        <= err_next;
      stval_prev_reg <= s_n_pstval;
      pdbin_prev_reg <= s_pdbin;
      n_pwr_prev_reg <= s_n_pwr;
    end
  end

  assign bus_dout    = dout_reg;
  assign bus_dout_oe = oe_reg;
  assign bus_rdy     = rdy_reg;
  assign reg_addr    = addr_reg;
  assign reg_rd      = rd_reg;
  assign reg_wr      = wr_reg;
  assign reg_wdata   = wdata_reg;
  assign reg_is_mem  = is_mem_reg;
  assign timeout_err = err_reg;

endmodule

// File: tb/tb_s100_slave_port.sv
// Bench for s100_slave_port: a latency-rule model of each bus cycle, checked on every falling clock edge.
module tb_s100_slave_port;

  localparam int TO = 255;
`ifdef S100_SLAVE_MEM_EN
  localparam bit MEM_EN = 1'b1;
`else
  localparam bit MEM_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [19:0] adr;
  logic [7:0]  din, rdata;
  logic        sinp, sout, smemr, smwrt, psync, n_pstval, pdbin, n_pwr, ack;
  logic [7:0]  dout, wdata;
  logic [19:0] raddr;
  logic        oe, rdy, rd, wr, is_mem, terr;

  s100_slave_port #(.TIMEOUT_CYC(TO)) dut (
    .clockIn(clk), .s100_n_RESET(rst_n), .bus_adr(adr), .bus_din(din),
    .bus_sINP(sinp), .bus_sOUT(sout), .bus_sMEMR(smemr), .bus_sMWRT(smwrt),
    .bus_pSYNC(psync), .bus_n_pSTVAL(n_pstval), .bus_pDBIN(pdbin), .bus_n_pWR(n_pwr),
    .bus_dout(dout), .bus_dout_oe(oe), .bus_rdy(rdy), .reg_addr(raddr),
    .reg_rd(rd), .reg_wr(wr), .reg_wdata(wdata), .reg_rdata(rdata),
    .reg_ack(ack), .reg_is_mem(is_mem), .timeout_err(terr)
  );

  int errors = 0, checks = 0;
  int rd_seen = 0, wr_seen = 0, rdy_low = 0, oe_seen = 0;
  int b_rd, b_wr, b_low, b_oe;
  bit mon_en = 1'b0;

  // Expected outputs, updated by the stimulus from the cycle's latency rules.
  logic        m_rdy, m_oe, m_rd, m_wr, m_is_mem, m_err;
  logic [7:0]  m_dout, m_wdata;
  logic [19:0] m_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic model_reset();
    m_rdy = 1'b1; m_oe = 1'b0; m_rd = 1'b0; m_wr = 1'b0; m_is_mem = 1'b0; m_err = 1'b0;
    m_dout = 8'h00; m_wdata = 8'h00; m_addr = 20'h0;
  endtask

  task automatic bus_idle();
    adr = 20'h0; din = 8'h0; sinp = 0; sout = 0; smemr = 0; smwrt = 0;
    psync = 0; n_pstval = 1; pdbin = 0; n_pwr = 1; ack = 0;
  endtask

  task automatic snap();
    b_rd = rd_seen; b_wr = wr_seen; b_low = rdy_low; b_oe = oe_seen;
  endtask

  function automatic bit f_hit(input logic [19:0] a, input bit mem);
    if (mem) return MEM_EN && ((a & 20'hF0000) == 20'hE0000);
    return (a[7:0] & 8'hF0) == 8'hA0;
  endfunction

  // Cycle start; n_pSTVAL falls before edge E1. Returns after E4 (decision edge).
  task automatic cycle_start(input logic [19:0] a, input bit hit, input bit mem);
    adr = a; psync = 1; tick();
    n_pstval = 0;
    ticks(3);                 // E3: address latched
    m_addr = a; psync = 0;
    tick();                   // E4: wait state asserted on a hit
    if (hit) begin m_rdy = 0; m_is_mem = mem; end
  endtask

  // k: ack is sampled k edges after entering the wait (0 = never); ab: pDBIN drop (0 = none).
  task automatic bus_read(input logic [19:0] a, input bit mem, input int k,
                          input logic [7:0] val, input int hold, input int ab);
    bit hit;
    int rel;
    hit = f_hit(a, mem);
    sinp = !mem; smemr = mem; pdbin = 1;
    cycle_start(a, hit, mem);
    if (hit) m_rd = 1;
    tick();
    m_rd = 0;
    if (hit) begin
      rel = TO + 1;
      if (k >= 1 && k < rel) rel = k;
      if (ab >= 1 && ab + 2 < rel) rel = ab + 2;
      for (int i = 1; i <= rel; i++) begin
        if (i == k) begin ack = 1; rdata = val; end
        if (i == ab) pdbin = 0;
        tick();
        ack = 0;
      end
      m_rdy = 1;
      if (!(ab >= 1 && rel == ab + 2)) begin
        if (rel == k) m_dout = val;
        else begin m_dout = 8'hFF; m_err = 1; end
        tick(); m_oe = 1;
        ticks(hold);
        pdbin = 0;
        ticks(2);
        tick(); m_oe = 0;
      end
    end
    n_pstval = 1; sinp = 0; smemr = 0; pdbin = 0;
    ticks(5);
  endtask

  task automatic bus_write(input logic [19:0] a, input logic [7:0] d, input int k);
    bit hit;
    hit = f_hit(a, 1'b0);
    sout = 1;
    cycle_start(a, hit, 1'b0);
    din = d; n_pwr = 0;
    ticks(3);
    if (hit) begin m_wr = 1; m_wdata = d; end
    tick();
    m_wr = 0;
    if (hit) begin
      ticks(k - 1);
      ack = 1;
      tick();
      ack = 0; m_rdy = 1;
    end
    n_pwr = 1; n_pstval = 1; sout = 0;
    ticks(5);
  endtask

  initial begin
    rst_n = 0; rdata = 8'h00;
    bus_idle();
    model_reset();
    fork
      forever begin
        @(negedge clk);
        if (mon_en) begin
          chk("rdy", rdy, m_rdy);           chk("oe", oe, m_oe);
          chk("dout", dout, m_dout);        chk("reg_rd", rd, m_rd);
          chk("reg_wr", wr, m_wr);          chk("wdata", wdata, m_wdata);
          chk("addr", raddr, m_addr);       chk("is_mem", is_mem, m_is_mem);
          chk("timeout_err", terr, m_err);
          if (rd) rd_seen++;
          if (wr) wr_seen++;
          if (!rdy) rdy_low++;
          if (oe) oe_seen++;
        end
      end
    join_none

    ticks(3);
    chk("rst_rdy", rdy, 1'b1);   chk("rst_oe", oe, 1'b0);   chk("rst_dout", dout, 8'h00);
    chk("rst_addr", raddr, 20'h0); chk("rst_rd", rd, 1'b0); chk("rst_err", terr, 1'b0);
    rst_n = 1;
    ticks(2);
    mon_en = 1;

    ack = 1; tick(); ack = 0; ticks(2);    // stray ack while idle

    snap(); bus_read(20'h000A3, 1'b0, 5, 8'h5A, 2, 0);
    chk("rd_a3_dout", dout, 8'h5A);
    chk("rd_a3_pulses", 32'(rd_seen - b_rd), 32'd1);
    chk("rd_a3_wait", 32'(rdy_low - b_low), 32'd6);
    chk("rd_a3_oe", 32'(oe_seen - b_oe), 32'd5);

    snap(); bus_write(20'h000A7, 8'hC3, 2);
    chk("wr_a7_wdata", wdata, 8'hC3);
    chk("wr_a7_addr", raddr[7:0], 8'hA7);
    chk("wr_a7_pulses", 32'(wr_seen - b_wr), 32'd1);
    chk("wr_a7_wait", 32'(rdy_low - b_low), 32'd6);

    snap(); bus_read(20'h00050, 1'b0, 5, 8'h11, 2, 0);
    chk("miss_rd", 32'(rd_seen - b_rd), 32'd0);
    chk("miss_wait", 32'(rdy_low - b_low), 32'd0);
    chk("miss_oe", 32'(oe_seen - b_oe), 32'd0);

    snap(); bus_read(20'hE1234, 1'b1, 3, 8'h96, 1, 0);
    chk("mem_is_mem", is_mem, MEM_EN);
    chk("mem_rd", 32'(rd_seen - b_rd), MEM_EN ? 32'd1 : 32'd0);

    snap(); bus_read(20'h000A1, 1'b0, 256, 8'h3C, 1, 0);
    chk("ack_at_expiry_dout", dout, 8'h3C);
    chk("ack_at_expiry_err", terr, 1'b0);
    chk("ack_at_expiry_wait", 32'(rdy_low - b_low), 32'd257);

    snap(); bus_read(20'h000A2, 1'b0, 0, 8'h00, 1, 0);
    chk("timeout_dout", dout, 8'hFF);
    chk("timeout_err", terr, 1'b1);
    chk("timeout_wait", 32'(rdy_low - b_low), 32'd257);

    snap(); bus_read(20'h000A4, 1'b0, 0, 8'h00, 1, 3);
    chk("abort_wait", 32'(rdy_low - b_low), 32'd6);
    chk("abort_oe", 32'(oe_seen - b_oe), 32'd0);

    // Reset while the read waits for the back end.
    sinp = 1; pdbin = 1;
    cycle_start(20'h000A6, 1'b1, 1'b0);
    m_rd = 1; tick(); m_rd = 0;
    ticks(3);
    chk("pre_rst_rdy", rdy, 1'b0);
    mon_en = 0;
    #2 rst_n = 0;
    #1;
    chk("async_rst_rdy", rdy, 1'b1);
    chk("async_rst_oe", oe, 1'b0);
    chk("async_rst_err", terr, 1'b0);
    chk("async_rst_addr", raddr, 20'h0);
    bus_idle();
    model_reset();
    ticks(2);
    rst_n = 1;
    ticks(3);
    mon_en = 1;

    snap(); bus_read(20'h000A5, 1'b0, 2, 8'h77, 1, 0);
    chk("post_rst_dout", dout, 8'h77);
    chk("post_rst_pulses", 32'(rd_seen - b_rd), 32'd1);

    mon_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
